// File: rtl/rtr_link_pipeline.sv
// rtr_link_pipeline: per-port channel/flow-control delay lines with per-VC credit tracking and sticky error flags
module rtr_link_pipeline #(
  parameter int num_ports = 5,
  parameter int num_vcs = 4,
  parameter int vc_idx_width = 2,
  parameter int channel_width = 68,
  parameter int flow_ctrl_width = 3,
  parameter int num_stages = 1,
  parameter int buffer_size = 8,
  parameter int cnt_width = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic [num_ports*channel_width-1:0] channel_in_ip,
  output logic [num_ports*channel_width-1:0] channel_out_op,
  input  logic [num_ports*flow_ctrl_width-1:0] flow_ctrl_in_op,
  output logic [num_ports*flow_ctrl_width-1:0] flow_ctrl_out_ip,
  output logic [num_ports*num_vcs*cnt_width-1:0] credit_count_pv,
  output logic [num_ports-1:0] error_ip,
  output logic error
);
  localparam int ch_w = num_ports*channel_width;
  localparam int fc_w = num_ports*flow_ctrl_width;
  localparam logic [cnt_width-1:0] full = cnt_width'(buffer_size);
  if (num_stages == 0) begin : g_comb
    assign channel_out_op = channel_in_ip;
    assign flow_ctrl_out_ip = flow_ctrl_in_op;
  end else begin : g_pipe
    logic [ch_w-1:0] ch_q [num_stages];
    logic [fc_w-1:0] fc_q [num_stages];
    always_ff @(posedge clk or posedge reset)
      if (reset) begin
        for (int i = 0; i < num_stages; i++) begin
          ch_q[i] <= '0;
          fc_q[i] <= '0;
        end
      end else begin
        ch_q[0] <= channel_in_ip;
        fc_q[0] <= flow_ctrl_in_op;
        for (int i = 1; i < num_stages; i++) begin
          ch_q[i] <= ch_q[i-1];
          fc_q[i] <= fc_q[i-1];
        end
      end
    assign channel_out_op = ch_q[num_stages-1];
    assign flow_ctrl_out_ip = fc_q[num_stages-1];
  end
  for (genvar p = 0; p < num_ports; p++) begin : g_port
    logic ch_v, fc_v, oor, err_q;
    logic [vc_idx_width-1:0] ch_vc, fc_vc;
    logic [num_vcs-1:0] fault;
    assign ch_v = channel_in_ip[p*channel_width];
    assign ch_vc = channel_in_ip[p*channel_width+1 +: vc_idx_width];
    assign fc_v = flow_ctrl_out_ip[p*flow_ctrl_width];
    assign fc_vc = flow_ctrl_out_ip[p*flow_ctrl_width+1 +: vc_idx_width];
    assign oor = (ch_v && int'(ch_vc) >= num_vcs) || (fc_v && int'(fc_vc) >= num_vcs);
    // Sends count against the router-side input, returns against the delayed credit
    for (genvar v = 0; v < num_vcs; v++) begin : g_vc
      logic dec, inc;
      logic [cnt_width-1:0] cnt;
      assign dec = ch_v && ch_vc == vc_idx_width'(v);
      assign inc = fc_v && fc_vc == vc_idx_width'(v);
      assign fault[v] = (dec && !inc && cnt == '0) || (inc && !dec && cnt == full);
      always_ff @(posedge clk or posedge reset)
        if (reset) cnt <= full;
        else if (dec && !inc && cnt != '0) cnt <= cnt - 1'b1;
        else if (inc && !dec && cnt != full) cnt <= cnt + 1'b1;
      assign credit_count_pv[(p*num_vcs+v)*cnt_width +: cnt_width] = cnt;
    end
    always_ff @(posedge clk or posedge reset)
      if (reset) err_q <= 1'b0;
      else if (oor || |fault) err_q <= 1'b1;
    assign error_ip[p] = err_q;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) error <= 1'b0;
    else error <= |error_ip;
endmodule

// File: tb/tb_rtr_link_pipeline.sv
// tb_rtr_link_pipeline: randomized and directed checks of two link pipelines (3 stages and 0 stages) against a queue-based model
module tb_rtr_link_pipeline;
  localparam int np = 5, nv = 4, vw = 2, cw = 68, fw = 3, bs = 8, cnw = 4;
  localparam int ns_a = 3, ns_b = 0;
  localparam int chw = np*cw, fcw = np*fw, ccw = np*nv*cnw;
  logic clk = 1'b0;
  logic reset;
  logic [chw-1:0] ch_in;
  logic [fcw-1:0] fc_in;
  logic [chw-1:0] ch_out_a, ch_out_b;
  logic [fcw-1:0] fc_out_a, fc_out_b;
  logic [ccw-1:0] cc_a, cc_b;
  logic [np-1:0] eip_a, eip_b;
  logic err_a, err_b;
  int n_tests = 0, n_fail = 0;
  int cnt [2][np][nv];
  bit errm [2][np];
  bit errq [2];
  logic [chw-1:0] hch [$];
  logic [fcw-1:0] hfc [$];
  int owed [np][nv];

  always #5 clk = ~clk;

  rtr_link_pipeline #(.num_ports(np), .num_vcs(nv), .vc_idx_width(vw), .channel_width(cw),
    .flow_ctrl_width(fw), .num_stages(ns_a), .buffer_size(bs), .cnt_width(cnw)) u_dut_a (
    .clk(clk), .reset(reset), .channel_in_ip(ch_in), .channel_out_op(ch_out_a),
    .flow_ctrl_in_op(fc_in), .flow_ctrl_out_ip(fc_out_a), .credit_count_pv(cc_a),
    .error_ip(eip_a), .error(err_a));

  rtr_link_pipeline #(.num_ports(np), .num_vcs(nv), .vc_idx_width(vw), .channel_width(cw),
    .flow_ctrl_width(fw), .num_stages(ns_b), .buffer_size(bs), .cnt_width(cnw)) u_dut_b (
    .clk(clk), .reset(reset), .channel_in_ip(ch_in), .channel_out_op(ch_out_b),
    .flow_ctrl_in_op(fc_in), .flow_ctrl_out_ip(fc_out_b), .credit_count_pv(cc_b),
    .error_ip(eip_b), .error(err_b));

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [chw-1:0] exp_ch(int ns);
    return ns == 0 ? ch_in : (hch.size() >= ns ? hch[ns-1] : '0);
  endfunction

  function automatic logic [fcw-1:0] exp_fc(int ns);
    return ns == 0 ? fc_in : (hfc.size() >= ns ? hfc[ns-1] : '0);
  endfunction

  function automatic logic [ccw-1:0] exp_cc(int k);
    logic [ccw-1:0] e = '0;
    for (int p = 0; p < np; p++)
      for (int v = 0; v < nv; v++) e[(p*nv+v)*cnw +: cnw] = cnw'(cnt[k][p][v]);
    return e;
  endfunction

  function automatic logic [np-1:0] exp_eip(int k);
    logic [np-1:0] e = '0;
    for (int p = 0; p < np; p++) e[p] = errm[k][p];
    return e;
  endfunction

  task automatic compare_all();
    check("a_channel_out", 512'(ch_out_a), 512'(exp_ch(ns_a)));
    check("a_flow_ctrl_out", 512'(fc_out_a), 512'(exp_fc(ns_a)));
    check("a_credit_count", 512'(cc_a), 512'(exp_cc(0)));
    check("a_error_ip", 512'(eip_a), 512'(exp_eip(0)));
    check("a_error", 512'(err_a), 512'(errq[0]));
    check("b_channel_out", 512'(ch_out_b), 512'(exp_ch(ns_b)));
    check("b_flow_ctrl_out", 512'(fc_out_b), 512'(exp_fc(ns_b)));
    check("b_credit_count", 512'(cc_b), 512'(exp_cc(1)));
    check("b_error_ip", 512'(eip_b), 512'(exp_eip(1)));
    check("b_error", 512'(err_b), 512'(errq[1]));
  endtask

  task automatic model_reset();
    hch.delete();
    hfc.delete();
    for (int k = 0; k < 2; k++) begin
      errq[k] = 0;
      for (int p = 0; p < np; p++) begin
        errm[k][p] = 0;
        for (int v = 0; v < nv; v++) cnt[k][p][v] = bs;
      end
    end
    for (int p = 0; p < np; p++)
      for (int v = 0; v < nv; v++) owed[p][v] = 0;
  endtask

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      logic [fcw-1:0] fp = exp_fc(k == 0 ? ns_a : ns_b);
      bit any = 0;
      for (int p = 0; p < np; p++) any |= errm[k][p];
      errq[k] = any;
      for (int p = 0; p < np; p++) begin
        bit cv = ch_in[p*cw];
        int cvc = int'(ch_in[p*cw+1 +: vw]);
        bit fv = fp[p*fw];
        int fvc = int'(fp[p*fw+1 +: vw]);
        bit bad = (cv && cvc >= nv) || (fv && fvc >= nv);
        for (int v = 0; v < nv; v++) begin
          bit d = cv && cvc == v;
          bit i = fv && fvc == v;
          if (d && !i) begin
            if (cnt[k][p][v] == 0) bad = 1; else cnt[k][p][v]--;
          end else if (i && !d) begin
            if (cnt[k][p][v] == bs) bad = 1; else cnt[k][p][v]++;
          end
        end
        if (bad) errm[k][p] = 1;
      end
    end
    hch.push_front(ch_in);
    hfc.push_front(fc_in);
    if (hch.size() > 8) begin
      void'(hch.pop_back());
      void'(hfc.pop_back());
    end
  endtask

  task automatic cycle(input logic [chw-1:0] c, input logic [fcw-1:0] f);
    ch_in = c;
    fc_in = f;
    @(negedge clk);
    compare_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle('0, '0);
  endtask

  task automatic do_reset();
    #2 reset = 1'b1;
    #1;
    model_reset();
    compare_all();
    ch_in = '0;
    fc_in = '0;
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  function automatic logic [chw-1:0] flit(int p, int vc, logic [64:0] pl);
    logic [chw-1:0] c = '0;
    c[p*cw +: cw] = {pl, vw'(vc), 1'b1};
    return c;
  endfunction

  function automatic logic [fcw-1:0] cred(int p, int vc);
    logic [fcw-1:0] f = '0;
    f[p*fw +: fw] = {vw'(vc), 1'b1};
    return f;
  endfunction

  function automatic logic [64:0] rnd_pl();
    return {$urandom, $urandom, $urandom};
  endfunction

  task automatic random_cycle(input bit legal);
    logic [chw-1:0] c = '0;
    logic [fcw-1:0] f = '0;
    for (int p = 0; p < np; p++) begin
      int cv = $urandom_range(nv-1);
      int fv = $urandom_range(nv-1);
      logic [cw-1:0] w = {rnd_pl(), vw'(cv), 1'b0};
      if ($urandom_range(1) == 1 && (!legal || owed[p][cv] < bs)) begin
        w[0] = 1'b1;
        owed[p][cv]++;
      end
      c[p*cw +: cw] = w;
      if ($urandom_range(1) == 1 && (!legal || owed[p][fv] > 0)) begin
        f[p*fw +: fw] = {vw'(fv), 1'b1};
        owed[p][fv]--;
      end
    end
    cycle(c, f);
  endtask

  initial begin
    ch_in = '0;
    fc_in = '0;
    reset = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    compare_all();
    reset = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      logic [chw-1:0] c = '0;
      c[2*cw +: cw] = cw'(i);
      cycle(c, '0);
    end
    idle(6);
    for (int i = 0; i < 9; i++) cycle(flit(1, 3, rnd_pl()), '0);
    idle(3);
    do_reset();
    cycle('0, cred(0, 1));
    idle(4);
    do_reset();
    for (int i = 0; i < 4; i++) cycle(flit(0, 2, rnd_pl()), '0);
    cycle(flit(0, 2, rnd_pl()), cred(0, 2));
    cycle('0, cred(0, 2));
    idle(4);
    do_reset();
    for (int i = 0; i < 5; i++) cycle(flit(4, 0, rnd_pl()), '0);
    for (int i = 0; i < 5; i++) cycle('0, cred(4, 0));
    idle(4);
    do_reset();
    for (int i = 0; i < 300; i++) random_cycle(1);
    do_reset();
    idle(5);
    for (int i = 0; i < 200; i++) random_cycle(0);
    idle(4);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
